// File: rtl/clint_timer_pkg.sv
// Shared definitions for the CLINT machine timer: bus widths, register word
// indices and CTRL field layout.
package clint_timer_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] CLINT_MTIME_LO    = 3'd0;
    localparam logic [2:0] CLINT_MTIME_HI    = 3'd1;
    localparam logic [2:0] CLINT_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] CLINT_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] CLINT_MSIP        = 3'd4;
    localparam logic [2:0] CLINT_CTRL        = 3'd5;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int CTRL_PRESCALE_MSB = 23;

    function automatic logic [DATA_WIDTH-1:0] ctrl_pack(input logic en,
                                                        input logic [15:0] prescale);
        logic [DATA_WIDTH-1:0] word;
        word = '0;
        word[CTRL_EN_BIT] = en;
        word[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = prescale;
        return word;
    endfunction

endpackage

// File: rtl/clint_timer_prescaler.sv
// Prescale counter for mtime: issues one tick every (prescale + 1) enabled
// cycles; a clear restarts the count from zero.
module timer_prescaler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [15:0] prescale_i,
    input  logic        clear_i,
    output logic        tick_o
);

    logic [15:0] pc;
    logic        terminal;

    assign terminal = (pc == prescale_i);
    assign tick_o   = en_i & terminal;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc <= 16'd0;
        end else if (clear_i) begin
            pc <= 16'd0;
        end else if (en_i) begin
            pc <= terminal ? 16'd0 : pc + 16'd1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer / software interrupt slave on the data-RAM bus.
// Holds mtime, mtimecmp, msip and CTRL; rdata is a combinational OR-muxable read.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RST = 16'd0,
    parameter logic        EN_RST       = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  irq_timer_o,
    output logic                  irq_software_o
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        ctrl_en;
    logic [15:0] ctrl_prescale;
    logic        irq_timer_q;
    logic        tick;

    logic [2:0]  idx;
    logic        wr;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_msip;
    logic        wr_ctrl;

    logic        unused_addr;

    assign idx         = addr_i[4:2];
    assign wr          = ce_i & we_i;
    assign wr_mtime_lo = wr && (idx == CLINT_MTIME_LO);
    assign wr_mtime_hi = wr && (idx == CLINT_MTIME_HI);
    assign wr_cmp_lo   = wr && (idx == CLINT_MTIMECMP_LO);
    assign wr_cmp_hi   = wr && (idx == CLINT_MTIMECMP_HI);
    assign wr_msip     = wr && (idx == CLINT_MSIP);
    assign wr_ctrl     = wr && (idx == CLINT_CTRL);

    assign unused_addr = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};

    timer_prescaler u_prescaler (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (ctrl_en),
        .prescale_i (ctrl_prescale),
        .clear_i    (wr_ctrl),
        .tick_o     (tick)
    );

    // A write to either half wins over the tick; the other half just holds.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtime <= 64'd0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= wdata_i;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= wdata_i;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= wdata_i;
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            msip          <= 1'b0;
            ctrl_en       <= EN_RST;
            ctrl_prescale <= PRESCALE_RST;
        end else begin
            if (wr_msip) begin
                msip <= wdata_i[0];
            end
            if (wr_ctrl) begin
                ctrl_en       <= wdata_i[CTRL_EN_BIT];
                ctrl_prescale <= wdata_i[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
            end
        end
    end

    // Compare uses the registered values, so the irq lags mtime/mtimecmp by one edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_timer_q <= 1'b0;
        end else begin
            irq_timer_q <= (mtime >= mtimecmp);
        end
    end

    assign irq_timer_o    = irq_timer_q;
    assign irq_software_o = msip;

    always_comb begin
        rdata_o = '0;
        if (ce_i && !we_i) begin
            case (idx)
                CLINT_MTIME_LO:    rdata_o = mtime[31:0];
                CLINT_MTIME_HI:    rdata_o = mtime[63:32];
                CLINT_MTIMECMP_LO: rdata_o = mtimecmp[31:0];
                CLINT_MTIMECMP_HI: rdata_o = mtimecmp[63:32];
                CLINT_MSIP:        rdata_o = {31'd0, msip};
                CLINT_CTRL:        rdata_o = ctrl_pack(ctrl_en, ctrl_prescale);
                default:           rdata_o = '0;
            endcase
        end
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped machine timer and software-interrupt responder on the core's data-RAM bus.
- The core's data-RAM port is the initiator: ce, addr, wdata and we go out; rdata comes back.
- This block is the slave-side endpoint of that port.
- It produces the irq_timer_i and irq_software_i inputs of the core.
- Holds a free-running 64-bit mtime counter with a programmable prescaler, a 64-bit mtimecmp compare register, and an msip bit.
- An external interconnect decodes the region and drives ce_i.

Parameters:
- PRESCALE_RST, 16'd0: reset value of CTRL.PRESCALE. A value of 0 means mtime ticks every clk_i cycle.
- EN_RST, 1'b1: reset value of CTRL.EN.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; asynchronous, active-low
- ce_i  in  1  slave select from the bus, qualifies the access
- we_i  in  1  1 = write, 0 = read; ignored when ce_i = 0
- addr_i  in  ADDR_WIDTH (32)  byte address; only addr_i[4:2] is decoded
- wdata_i  in  DATA_WIDTH (32)  write data, full word only
- rdata_o  out  DATA_WIDTH (32)  read data, combinational
- irq_timer_o  out  1  machine timer interrupt, to the core's irq_timer_i
- irq_software_o  out  1  machine software interrupt, to the core's irq_software_i

Behaviour:
- Register map (word offsets):
  - 0x00 MTIME_LO, RW
  - 0x04 MTIME_HI, RW
  - 0x08 MTIMECMP_LO, RW
  - 0x0C MTIMECMP_HI, RW
  - 0x10 MSIP: bit0 RW, bits 31:1 read as 0
  - 0x14 CTRL: bit0 EN, bits 23:8 PRESCALE, all other bits read as 0 and ignore writes
  - 0x18 and 0x1C are unmapped: reads return 0, writes are ignored.
  - addr_i[1:0] and addr_i[31:5] are ignored, so the map aliases.
- Reset (rst_i low, asynchronous):
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0.
  - EN = EN_RST, PRESCALE = PRESCALE_RST, prescale counter = 0.
  - irq_timer_o = 0, irq_software_o = 0.
  - rdata_o is combinational, so it is 0 whenever ce_i = 0 (including in reset).
- Read:
  - Zero wait states: when ce_i = 1 and we_i = 0, rdata_o reflects the registered value in the same cycle.
  - When ce_i = 0, rdata_o = 0 so the bus can OR-mux slaves.
  - Reads have no side effects.
- Write:
  - When ce_i = 1 and we_i = 1, the addressed word is updated on the rising edge of clk_i.
  - Full 32-bit writes only; there are no byte strobes.
- Prescaler:
  - The counter pc is 16 bits.
  - When EN = 1: if pc == PRESCALE, a tick is issued and pc becomes 0; otherwise pc increments.
  - When EN = 0: pc holds and no ticks are issued.
  - A write to CTRL clears pc to 0 on the same edge.
- mtime:
  - Increments by 1 on each tick and wraps from 2^64-1 to 0.
  - A write to MTIME_LO or MTIME_HI in a tick cycle: the written half takes wdata_i, the other half holds, and no increment is applied that cycle.
  - There is no carry into a half being written.
- irq_timer_o:
  - Registered: the next value is (mtime >= mtimecmp), unsigned 64-bit, evaluated on the current registered values.
  - It asserts 1 cycle after mtime first satisfies the compare and is level-sensitive.
  - It is cleared only by raising mtimecmp or lowering mtime; the deassertion appears on the edge after the register update.
- irq_software_o: equals the msip bit0 register directly, with no extra delay.
- mtimecmp can be updated while irq_timer_o = 1; the result is the registered compare rule above.
- Software must write 64-bit values hi/lo in a sequence safe against spurious irq. No atomic 64-bit access is provided.
- Reset asserted mid-access aborts the access, and every register returns to its reset value immediately.

Decomposition:
- Shared defines header additions:
  - CLINT_MTIME_LO, CLINT_MTIME_HI, CLINT_MTIMECMP_LO, CLINT_MTIMECMP_HI, CLINT_MSIP, CLINT_CTRL as 3-bit word indices.
  - CTRL field positions.
  - Reuse the existing ADDR_WIDTH and DATA_WIDTH.
- One sub-module, timer_prescaler:
  - Inputs: clk_i, rst_i, en_i, prescale_i[15:0], clear_i.
  - Output: tick_o.
  - Contains pc and the tick logic.
- Register file, compare and read mux stay in clint_timer.

Test Plan:
- Reset, then read all six offsets → 0, 0, FFFFFFFF, FFFFFFFF, 0, 0x0000_0001 (PRESCALE_RST = 0, EN_RST = 1); irq_timer_o = 0, irq_software_o = 0.
- PRESCALE = 3, EN = 1, idle 40 cycles → MTIME_LO reads 10.
- EN = 0, idle 20 cycles → value unchanged.
- Write MTIMECMP_HI = 0, then MTIMECMP_LO = 50, with mtime at 0 and PRESCALE = 0 → irq_timer_o rises exactly 1 cycle after mtime reaches 50.
- Then write MTIMECMP_LO = 1000 → irq_timer_o falls on the following edge.
- Set MTIME = 0xFFFF_FFFF_FFFF_FFFE, PRESCALE = 0 → after 2 ticks it reads 0/0 (wrap).
- Write MTIME_LO = 0x100 in a tick cycle → reads 0x100, not 0x101.
- Write MSIP = 0xFFFF_FFFF → irq_software_o = 1 after the edge and MSIP reads 1.
- Write MSIP = 0 → irq_software_o = 0.
- Read offset 0x18 → 0.
- ce_i = 0 with addr 0x00 → rdata_o = 0.
- Assert rst_i low asynchronously mid-write and mid-count → all outputs and registers take their reset values without waiting for a clock edge.
